otf_quotient_accumulator: RTL and testbench

- Sequential on-the-fly quotient converter for the iterative SRT FP divider/sqrt.
- Accepts one signed-digit quotient digit per iteration.
- Maintains Q and QM = Q − 1 ulp without carry propagation.
- After a programmed digit count, presents the final quotient, selecting QM when the final remainder is negative, through a valid/ready handshake.
- Generalises the single-step combinational converter to radix 2 or 4, arbitrary width, an iteration controller, and error/flush handling.

---
 rtl/otf_quotient_accumulator.sv | 96 +++++++++
 tb/tb_otf_quotient_accumulator.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/otf_quotient_accumulator.sv
// otf_quotient_accumulator: iterative on-the-fly signed-digit quotient converter.
// Keeps Q and QM = Q - 1 ulp so each digit is absorbed without carry propagation.
module otf_quotient_accumulator #(
    parameter int  WIDTH      = 32,
    parameter int  RADIX_LOG2 = 2,
    parameter int  MAX_ITERS  = WIDTH / RADIX_LOG2,
    localparam int CW         = $clog2(MAX_ITERS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CW-1:0]    iters_i,
    input  logic             digit_valid_i,
    input  logic [2:0]       digit_i,
    input  logic             rem_neg_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             result_valid_o,
    input  logic             result_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qm_o,
    output logic             bad_digit_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    logic [1:0]            state_q, state_d;
    logic [WIDTH-1:0]      q_q, q_d, qm_q, qm_d, quot_q, quot_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  bad_q, bad_d;
    logic                  d_neg, d_pos, illegal;
    logic [RADIX_LOG2-1:0] lo_m1;
    logic [WIDTH-1:0]      q_src, qm_src, q_nx, qm_nx;
    assign d_neg   = digit_i[2];
    assign d_pos   = ~digit_i[2] & |digit_i[1:0];
    // radix 2 accepts only -1/0/+1; radix 4 rejects only -4
    assign illegal = (RADIX_LOG2 == 1) ? (digit_i[2] ? digit_i != 3'b111 : digit_i[1])
                                       : digit_i == 3'b100;
    assign lo_m1   = digit_i[RADIX_LOG2-1:0] - RADIX_LOG2'(1);
    assign q_src   = d_neg ? qm_q : q_q;
    assign qm_src  = d_pos ? q_q : qm_q;
    assign q_nx    = (q_src << RADIX_LOG2) | WIDTH'(digit_i[RADIX_LOG2-1:0]);
    assign qm_nx   = (qm_src << RADIX_LOG2) | WIDTH'(lo_m1);
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        cnt_d   = cnt_q;
        bad_d   = bad_q;
        quot_d  = quot_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (state_q == IDLE && start_i) begin
            state_d = ACCUM;
            q_d     = '0;
            qm_d    = '1;
            cnt_d   = (iters_i == '0) ? CW'(1) : iters_i;
            bad_d   = 1'b0;
        end else if (state_q == ACCUM && digit_valid_i) begin
            q_d   = q_nx;
            qm_d  = qm_nx;
            cnt_d = cnt_q - CW'(1);
            bad_d = bad_q | illegal;
            if (cnt_q == CW'(1)) begin
                state_d = DONE;
                quot_d  = rem_neg_i ? qm_nx : q_nx;
            end
        end else if (state_q == DONE && result_ready_i) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            qm_q    <= '1;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
            quot_q  <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            cnt_q   <= cnt_d;
            bad_q   <= bad_d;
            quot_q  <= quot_d;
        end
    end
    assign busy_o         = state_q == ACCUM;
    assign result_valid_o = state_q == DONE;
    assign quotient_o     = quot_q;
    assign q_o            = q_q;
    assign qm_o           = qm_q;
    assign bad_digit_o    = bad_q;
endmodule

// File: tb/tb_otf_quotient_accumulator.sv
// tb_otf_quotient_accumulator: three configurations driven in lockstep and checked
// against an arithmetic model of the signed-digit quotient value.
module tb_otf_quotient_accumulator;
    logic       clk = 1'b0, rst = 1'b1, start_i = 1'b0, digit_valid_i = 1'b0;
    logic       rem_neg_i = 1'b0, flush_i = 1'b0, result_ready_i = 1'b0;
    logic [2:0] iters_i = '0, digit_i = '0;
    logic [7:0] q0, qm0, quo0;
    logic [3:0] q1, qm1, quo1, q2, qm2, quo2;
    logic       busy0, busy1, busy2, rv0, rv1, rv2, bad0, bad1, bad2;
    logic [7:0] o_q[3], o_qm[3], o_quo[3];
    logic       o_busy[3], o_rv[3], o_bad[3];
    int         cfg_w[3] = '{8, 4, 4};
    int         cfg_k[3] = '{2, 2, 1};
    longint     mq[3], mqm[3], mquo[3];
    bit         mbad[3];
    logic [7:0] snap_q[3], snap_qm[3], fin_q[3], fin_qm[3], fin_quo[3];
    int         dq[$];
    int         n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    otf_quotient_accumulator #(.WIDTH(8), .RADIX_LOG2(2), .MAX_ITERS(4)) u_r4w8 (
        .clk(clk), .rst(rst), .start_i(start_i), .iters_i(iters_i), .digit_valid_i(digit_valid_i),
        .digit_i(digit_i), .rem_neg_i(rem_neg_i), .flush_i(flush_i), .busy_o(busy0),
        .result_valid_o(rv0), .result_ready_i(result_ready_i), .quotient_o(quo0), .q_o(q0),
        .qm_o(qm0), .bad_digit_o(bad0));
    otf_quotient_accumulator #(.WIDTH(4), .RADIX_LOG2(2), .MAX_ITERS(4)) u_r4w4 (
        .clk(clk), .rst(rst), .start_i(start_i), .iters_i(iters_i), .digit_valid_i(digit_valid_i),
        .digit_i(digit_i), .rem_neg_i(rem_neg_i), .flush_i(flush_i), .busy_o(busy1),
        .result_valid_o(rv1), .result_ready_i(result_ready_i), .quotient_o(quo1), .q_o(q1),
        .qm_o(qm1), .bad_digit_o(bad1));
    otf_quotient_accumulator #(.WIDTH(4), .RADIX_LOG2(1), .MAX_ITERS(4)) u_r2w4 (
        .clk(clk), .rst(rst), .start_i(start_i), .iters_i(iters_i), .digit_valid_i(digit_valid_i),
        .digit_i(digit_i), .rem_neg_i(rem_neg_i), .flush_i(flush_i), .busy_o(busy2),
        .result_valid_o(rv2), .result_ready_i(result_ready_i), .quotient_o(quo2), .q_o(q2),
        .qm_o(qm2), .bad_digit_o(bad2));
    assign o_q[0] = q0;   assign o_q[1] = {4'h0, q1};   assign o_q[2] = {4'h0, q2};
    assign o_qm[0] = qm0; assign o_qm[1] = {4'h0, qm1}; assign o_qm[2] = {4'h0, qm2};
    assign o_quo[0] = quo0; assign o_quo[1] = {4'h0, quo1}; assign o_quo[2] = {4'h0, quo2};
    assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;
    assign o_rv[0] = rv0;     assign o_rv[1] = rv1;     assign o_rv[2] = rv2;
    assign o_bad[0] = bad0;   assign o_bad[1] = bad1;   assign o_bad[2] = bad2;
    function automatic longint md(longint a, longint m);
        return ((a % m) + m) % m;
    endfunction
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic model_reset(bit full);
        for (int i = 0; i < 3; i++) begin
            mq[i]   = 0;
            mqm[i]  = (longint'(1) << cfg_w[i]) - 1;
            mbad[i] = 1'b0;
            if (full) mquo[i] = 0;
        end
    endtask
    // Legal digits on a consistent pair simply append the digit value: Q = Q*r + d, QM = Q - 1.
    // Otherwise fall back to the select-and-append-low-bits rule for undefined results.
    task automatic model_digit(int d, bit last, bit rn);
        for (int i = 0; i < 3; i++) begin
            longint r = longint'(1) << cfg_k[i];
            longint m = longint'(1) << cfg_w[i];
            bit legal = (d >= -(r - 1)) && (d <= r - 1);
            if (legal && !mbad[i]) begin
                mq[i]  = md(mq[i] * r + d, m);
                mqm[i] = md(mq[i] - 1, m);
            end else begin
                longint sq  = (d >= 0) ? mq[i] : mqm[i];
                longint sqm = (d > 0) ? mq[i] : mqm[i];
                mq[i]  = md(sq * r + md(d, r), m);
                mqm[i] = md(sqm * r + md(d - 1, r), m);
            end
            mbad[i] = mbad[i] | !legal;
            if (last) mquo[i] = rn ? mqm[i] : mq[i];
        end
    endtask
    task automatic check_all(string tag, bit eb, bit erv);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.q[%0d]", tag, i), o_q[i], mq[i]);
            chk($sformatf("%s.qm[%0d]", tag, i), o_qm[i], mqm[i]);
            chk($sformatf("%s.quo[%0d]", tag, i), o_quo[i], mquo[i]);
            chk($sformatf("%s.busy[%0d]", tag, i), o_busy[i], eb);
            chk($sformatf("%s.rv[%0d]", tag, i), o_rv[i], erv);
            chk($sformatf("%s.bad[%0d]", tag, i), o_bad[i], mbad[i]);
        end
    endtask
    task automatic convert(int iters, bit rn, int gap, int rdly);
        int n = (iters == 0) ? 1 : iters;
        start_i = 1'b1; iters_i = 3'(iters); digit_valid_i = 1'b1; digit_i = 3'(1);
        tick();
        start_i = 1'b0; digit_valid_i = 1'b0;
        model_reset(1'b0);
        check_all("start", 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (gap) begin
                digit_valid_i = 1'b0; digit_i = 3'($urandom);
                tick();
                check_all("bubble", 1'b1, 1'b0);
            end
            digit_valid_i = 1'b1; digit_i = 3'(dq[i]);
            rem_neg_i = (i == n - 1) ? rn : 1'($urandom);
            tick();
            digit_valid_i = 1'b0;
            model_digit(dq[i], i == n - 1, rn);
            for (int j = 0; j < 3; j++) begin
                if (i == 0) begin snap_q[j] = o_q[j]; snap_qm[j] = o_qm[j]; end
                fin_q[j] = o_q[j]; fin_qm[j] = o_qm[j]; fin_quo[j] = o_quo[j];
            end
            check_all("digit", i != n - 1, i == n - 1);
        end
        repeat (rdly) begin
            result_ready_i = 1'b0; start_i = 1'b1;
            tick();
            check_all("hold", 1'b0, 1'b1);
        end
        start_i = 1'b0; result_ready_i = 1'b1;
        tick();
        result_ready_i = 1'b0;
        check_all("release", 1'b0, 1'b0);
    endtask
    initial begin
        model_reset(1'b1);
        tick();
        check_all("reset", 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        dq = '{1, 2, -1, 0};
        convert(4, 1'b0, 0, 0);
        chk("tp1_quo", fin_quo[0], 8'h5C);
        chk("tp1_qm", fin_qm[0], 8'h5B);
        convert(4, 1'b1, 0, 0);
        chk("tp1n_quo", fin_quo[0], 8'h5B);
        dq = '{-1, 0, 0, 0};
        convert(4, 1'b0, 0, 1);
        chk("tp2_step1_q", snap_q[0], 8'hFF);
        chk("tp2_step1_qm", snap_qm[0], 8'hFE);
        chk("tp2_q", fin_q[0], 8'hC0);
        chk("tp2_qm", fin_qm[0], 8'hBF);
        dq = '{1, -3};
        convert(2, 1'b0, 0, 0);
        chk("tp3a_q", fin_q[1], 8'h1);
        chk("tp3a_qm", fin_qm[1], 8'h0);
        dq = '{1, 3};
        convert(2, 1'b0, 0, 0);
        chk("tp3b_q", fin_q[1], 8'h7);
        chk("tp3b_qm", fin_qm[1], 8'h6);
        dq = '{1, -1, 1, -1};
        convert(4, 1'b0, 2, 5);
        chk("tp4_q", fin_q[2], 8'h5);
        chk("tp4_qm", fin_qm[2], 8'h4);
        dq = '{3, 0, 1, 0};
        convert(4, 1'b0, 1, 2);
        chk("bad_sticky_idle", o_bad[2], 1'b1);
        dq = '{0, 0, 0, 0};
        convert(0, 1'b1, 0, 0);
        chk("bad_cleared", o_bad[2], 1'b0);
        start_i = 1'b1; iters_i = 3'd4;
        tick();
        start_i = 1'b0;
        model_reset(1'b0);
        for (int i = 0; i < 2; i++) begin
            digit_valid_i = 1'b1; digit_i = 3'(i + 1);
            tick();
            model_digit(i + 1, 1'b0, 1'b0);
        end
        flush_i = 1'b1; start_i = 1'b1; digit_i = 3'(1);
        tick();
        flush_i = 1'b0; start_i = 1'b0;
        check_all("flush", 1'b0, 1'b0);
        repeat (3) begin
            tick();
            check_all("idle_digit", 1'b0, 1'b0);
        end
        digit_valid_i = 1'b0;
        start_i = 1'b1; iters_i = 3'd4;
        tick();
        start_i = 1'b0;
        digit_valid_i = 1'b1; digit_i = 3'(2);
        tick();
        digit_valid_i = 1'b0;
        #3 rst = 1'b1;
        #1 model_reset(1'b1);
        check_all("async_rst", 1'b0, 1'b0);
        #1 rst = 1'b0;
        tick();
        dq = '{1, 1, 1, 1};
        convert(4, 1'b0, 0, 0);
        chk("post_rst_quo", fin_quo[0], 8'h55);
        repeat (40) begin
            bit narrow = 1'($urandom);
            dq.delete();
            repeat (4) dq.push_back(narrow ? int'($urandom_range(0, 2)) - 1 : int'($urandom_range(0, 7)) - 4);
            convert(int'($urandom_range(0, 4)), 1'($urandom), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
